demux_1_4_buf: RTL and testbench
================================

Name: demux_1_4_buf

Overview:
- Buffered 1-to-4 demultiplexer with a valid/ready handshake on every channel.
- Inverse of the datapath 4:1 select mux. Steers a single producer stream into one of four consumer channels, using a 2-bit select that travels with each word.
- Used where one source, such as the data-memory response path, feeds several pipeline consumers that can stall independently.
- An internal FIFO decouples producer and consumers. Ordering is strict FIFO, so head-of-line blocking is accepted.

Parameters:
- SIZE, 32, width of each data word.
- DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- in_data  input  SIZE  word to route.
- in_select  input  2  destination channel, 0..3.
- in_valid  input  1  producer offers in_data/in_select.
- in_ready  output  1  block can accept a word this cycle.
- out_0_data  output  SIZE  channel 0 data.
- out_1_data  output  SIZE  channel 1 data.
- out_2_data  output  SIZE  channel 2 data.
- out_3_data  output  SIZE  channel 3 data.
- out_valid  output  4  bit k asserted when channel k presents a word.
- out_ready  input  4  bit k asserted when consumer k accepts.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset, when rst_n=0 at a rising edge:
  - write/read pointers and count go to 0, so the FIFO is empty.
  - in_ready=1 from the first cycle after reset; out_valid=4'b0000; all out_k_data=0.
  - Reset mid-operation discards every stored entry. Nothing is emitted afterwards.
- Storage: each entry holds {select, data}, SIZE+2 bits.
- Push: occurs when in_valid && in_ready. in_ready = (count != DEPTH), derived from registered state only, with no combinational path from out_ready.
- Head presentation:
  - out_valid[k] = (count != 0) && (head_select == k). At most one bit of out_valid is set.
  - out_k_data = head data when out_valid[k]; otherwise 0.
- Pop: occurs when out_valid[head_select] && out_ready[head_select]. out_ready bits of non-selected channels are ignored.
- Latency: a word pushed into an empty FIFO at edge N is visible on its channel during cycle N+1. There is no same-cycle pass-through.
- Simultaneous push and pop in the same cycle: both happen and count is unchanged.
- When full, in_ready=0 even if a pop occurs that same cycle. The freed slot is offered on the next cycle.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is tracked separately: +1 on push-only, -1 on pop-only.
- Stability: once out_valid[k] is high, out_k_data and out_valid[k] hold until the pop.
- Every in_select value is legal. No error state exists.
- Outputs are combinational from registers only. No internal state machine is needed beyond the FIFO occupancy (empty / partial / full).

Decomposition:
- Shared package holds:
  - the select width (2)
  - channel count (4)
  - channel index constants CH_0..CH_3
  - the entry type {select, data}.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count). demux_1_4_buf instantiates it with WIDTH=SIZE+2 and adds the decode and handshake logic.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=1, out_valid=0000, count=0, all out data 0. After release, no word is emitted that was offered during reset.
- Routing: push 0xA0000000 with select 0, 0xA1 with select 1, 0xA2 with select 2, 0xA3 with select 3, all out_ready=1111 -> each word appears one cycle after its push, only on its channel; out_valid sequence is 0001, 0010, 0100, 1000.
- Backpressure: DEPTH=2, out_ready=0000, push 0x11 (select 2) and 0x22 (select 2) -> count=2 and in_ready=0. A third word is held by the producer. Raise out_ready[2] -> 0x11 pops, then the next cycle in_ready=1.
- Head-of-line blocking: push 0x5 (select 1), then 0x6 (select 3); set out_ready=1000 -> nothing pops, out_valid=0010. Then set out_ready=0010 -> 0x5 pops and out_valid becomes 1000 with 0x6.
- Simultaneous push and pop: count=1 steady stream, push and pop every cycle for 8 cycles with selects 0,1,2,3,0,1,2,3 -> count stays 1, words exit in order, and pointers wrap without loss.
- Reset mid-operation: with count=2, pulse rst_n=0 for 1 cycle -> count=0 and out_valid=0000 next cycle; the discarded words never appear.

Source files
------------

// File: rtl/demux_1_4_buf_pkg.sv
// Shared constants for the buffered 1:4 demux: select width, channel count, channel ids.
package demux_1_4_buf_pkg;
  localparam int SEL_W  = 2;
  localparam int NUM_CH = 4;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t CH_0 = 2'd0;
  localparam sel_t CH_1 = 2'd1;
  localparam sel_t CH_2 = 2'd2;
  localparam sel_t CH_3 = 2'd3;

  // One-hot channel mask for a select value.
  function automatic logic [NUM_CH-1:0] sel_onehot(sel_t s);
    logic [NUM_CH-1:0] m;
    m = '0;
    m[s] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/demux_1_4_buf_if.sv
// Producer stream plus four consumer channels of the buffered 1:4 demux.
interface demux_1_4_buf_if #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 2
);
  import demux_1_4_buf_pkg::*;

  logic [SIZE-1:0]         in_data;
  logic [SEL_W-1:0]        in_select;
  logic                    in_valid;
  logic                    in_ready;
  logic [SIZE-1:0]         out_0_data;
  logic [SIZE-1:0]         out_1_data;
  logic [SIZE-1:0]         out_2_data;
  logic [SIZE-1:0]         out_3_data;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [$clog2(DEPTH):0]  count;

  modport master (
    output in_data, in_select, in_valid, out_ready,
    input  in_ready, out_0_data, out_1_data, out_2_data, out_3_data, out_valid, count
  );

  modport slave (
    input  in_data, in_select, in_valid, out_ready,
    output in_ready, out_0_data, out_1_data, out_2_data, out_3_data, out_valid, count
  );
endinterface

// File: rtl/demux_1_4_buf_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers and a separately tracked occupancy count.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // Guard here so callers cannot overflow or underflow the pointers.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; contents are only observed while occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/demux_1_4_buf.sv
// Buffered 1:4 demux: FIFO of {select,data} entries, head steered to its channel.
module demux_1_4_buf
  import demux_1_4_buf_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_1_4_buf_if.slave   bus
);
  typedef struct packed {
    sel_t            sel;
    logic [SIZE-1:0] data;
  } entry_t;

  entry_t                          wr_e, hd_e;
  logic [SIZE+SEL_W-1:0]           rdata;
  logic                            full, empty, push, pop;
  logic [NUM_CH-1:0]               ch_vld;
  logic [NUM_CH-1:0][SIZE-1:0]     ch_data;
  logic [$clog2(DEPTH):0]          cnt;

  assign wr_e = '{sel: bus.in_select, data: bus.in_data};
  assign hd_e = rdata;

  // in_ready comes from registered occupancy only, so a pop never frees a slot same-cycle.
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign pop          = !empty && bus.out_ready[hd_e.sel];

  sync_fifo #(
    .WIDTH (SIZE + SEL_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wr_e),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_vld[k]  = !empty && (hd_e.sel == SEL_W'(k));
    assign ch_data[k] = ch_vld[k] ? hd_e.data : '0;
  end

  assign bus.out_valid  = ch_vld;
  assign bus.out_0_data = ch_data[CH_0];
  assign bus.out_1_data = ch_data[CH_1];
  assign bus.out_2_data = ch_data[CH_2];
  assign bus.out_3_data = ch_data[CH_3];
  assign bus.count      = cnt;
endmodule

// File: tb/tb_demux_1_4_buf.sv
// Directed bench for demux_1_4_buf: reset, routing, backpressure, HOL blocking, streaming, mid-op reset.
module tb_demux_1_4_buf;
  import demux_1_4_buf_pkg::*;

  localparam int SIZE  = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  demux_1_4_buf_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

  demux_1_4_buf #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SIZE-1:0] ch(int k);
    case (k)
      0:       return bus.out_0_data;
      1:       return bus.out_1_data;
      2:       return bus.out_2_data;
      default: return bus.out_3_data;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [SIZE-1:0] d, input logic [1:0] s);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_select = s;
  endtask

  logic [SIZE-1:0] rt_words [4];

  initial begin
    rt_words[0] = 32'hA000_0000;
    rt_words[1] = 32'h0000_00A1;
    rt_words[2] = 32'h0000_00A2;
    rt_words[3] = 32'h0000_00A3;

    // reset held 3 cycles with a word offered
    rst_n = 1'b0;
    bus.out_ready = 4'b0000;
    drive(1'b1, 32'hDEAD_BEEF, 2'd0);
    repeat (3) step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_data", 64'(bus.out_0_data | bus.out_1_data | bus.out_2_data | bus.out_3_data), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, '0, 2'd0);
    step();
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_count", 64'(bus.count), 64'd0);

    // routing: each word lands on its own channel one cycle after push
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, rt_words[i], 2'(i));
      step();
      drive(1'b0, '0, 2'd0);
      chk($sformatf("route_valid%0d", i), 64'(bus.out_valid), 64'(4'b0001 << i));
      chk($sformatf("route_data%0d", i), 64'(ch(i)), 64'(rt_words[i]));
      chk($sformatf("route_count%0d", i), 64'(bus.count), 64'd1);
    end
    step();
    chk("route_drain", 64'(bus.count), 64'd0);

    // backpressure on a full FIFO
    bus.out_ready = 4'b0000;
    drive(1'b1, 32'h11, 2'd2);
    step();
    drive(1'b1, 32'h22, 2'd2);
    step();
    chk("bp_count_full", 64'(bus.count), 64'd2);
    chk("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
    chk("bp_valid", 64'(bus.out_valid), 64'b0100);
    drive(1'b1, 32'h33, 2'd2);
    step();
    chk("bp_hold_count", 64'(bus.count), 64'd2);
    chk("bp_hold_head", 64'(bus.out_2_data), 64'h11);
    bus.out_ready = 4'b0100;
    step();
    chk("bp_pop_count", 64'(bus.count), 64'd1);
    chk("bp_in_ready_freed", 64'(bus.in_ready), 64'd1);
    chk("bp_head2", 64'(bus.out_2_data), 64'h22);
    step();
    drive(1'b0, '0, 2'd0);
    chk("bp_pushpop_count", 64'(bus.count), 64'd1);
    chk("bp_head3", 64'(bus.out_2_data), 64'h33);
    step();
    chk("bp_drain", 64'(bus.count), 64'd0);

    // head-of-line blocking
    bus.out_ready = 4'b0000;
    drive(1'b1, 32'h5, 2'd1);
    step();
    drive(1'b1, 32'h6, 2'd3);
    step();
    drive(1'b0, '0, 2'd0);
    bus.out_ready = 4'b1000;
    step();
    chk("hol_blocked_valid", 64'(bus.out_valid), 64'b0010);
    chk("hol_blocked_count", 64'(bus.count), 64'd2);
    chk("hol_blocked_data", 64'(bus.out_1_data), 64'h5);
    chk("hol_other_zero", 64'(bus.out_3_data), 64'd0);
    bus.out_ready = 4'b0010;
    step();
    chk("hol_next_valid", 64'(bus.out_valid), 64'b1000);
    chk("hol_next_data", 64'(bus.out_3_data), 64'h6);
    chk("hol_next_count", 64'(bus.count), 64'd1);
    bus.out_ready = 4'b1111;
    step();
    chk("hol_drain", 64'(bus.count), 64'd0);

    // steady push+pop at count=1, pointers wrap
    bus.out_ready = 4'b0000;
    drive(1'b1, 32'h100, 2'd0);
    step();
    chk("ss_head0", 64'(bus.out_0_data), 64'h100);
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h101 + 32'(i), 2'((i + 1) % 4));
      step();
      chk($sformatf("ss_count%0d", i), 64'(bus.count), 64'd1);
      chk($sformatf("ss_valid%0d", i), 64'(bus.out_valid), 64'(4'b0001 << ((i + 1) % 4)));
      chk($sformatf("ss_data%0d", i), 64'(ch((i + 1) % 4)), 64'(32'h101 + 32'(i)));
    end
    drive(1'b0, '0, 2'd0);
    step();
    chk("ss_drain", 64'(bus.count), 64'd0);

    // reset with two entries stored
    bus.out_ready = 4'b0000;
    drive(1'b1, 32'h77, 2'd0);
    step();
    drive(1'b1, 32'h88, 2'd1);
    step();
    drive(1'b0, '0, 2'd0);
    chk("mr_count_pre", 64'(bus.count), 64'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_count", 64'(bus.count), 64'd0);
    chk("mr_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 4'b1111;
    repeat (3) step();
    chk("mr_no_emit", 64'(bus.out_valid), 64'd0);
    chk("mr_data_zero", 64'(bus.out_0_data | bus.out_1_data), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
